// File: rtl/riscv_pkg.sv
// Shared types for the memory-port arbiter: FSM state and access owner.
package riscv_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable down-counter that tracks RAM read latency; done is high at zero.
module mem_lat_timer #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int CW = $clog2(MEM_LAT) + 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at zero so a stray dec after done is harmless.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port RAM between instruction fetch and the
// load/store stage; data has priority, bounded by a fetch starvation guard.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_valid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output arb_state_t          dbg_state
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // Handshake: a requester raises req with its inputs stable and holds them
  // until its one-cycle valid pulse; req and inputs are sampled only in IDLE.

  arb_state_t  state_q, state_d;
  arb_owner_t  owner_q, owner_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic timer_load, timer_dec, timer_done;
  logic grant_if;

  mem_lat_timer #(.MEM_LAT(MEM_LAT)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .dec  (timer_dec),
    .done (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    starve_d   = starve_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    if_valid   = 1'b0;
    dm_valid   = 1'b0;
    busy       = 1'b0;
    grant_if   = 1'b0;
    // Reset overrides everything so nothing leaks onto the RAM port.
    if (!rst) begin
      case (state_q)
        ARB_IDLE: begin
          if (if_req || dm_req) begin
            grant_if = if_req && (!dm_req || (starve_q == STARVE_MAX));
            mem_en   = 1'b1;
            if (grant_if) begin
              owner_d    = OWN_IF;
              starve_d   = '0;
              mem_addr   = if_addr;
              mem_be     = '1;
              timer_load = 1'b1;
              state_d    = ARB_WAIT;
            end else begin
              owner_d = OWN_DM;
              if (if_req && (starve_q != STARVE_MAX)) begin
                starve_d = starve_q + 1'b1;
              end
              mem_we    = dm_we;
              mem_addr  = dm_addr;
              mem_wdata = dm_wdata;
              mem_be    = dm_be;
              if (dm_we) begin
                state_d = ARB_RESP;
              end else begin
                timer_load = 1'b1;
                state_d    = ARB_WAIT;
              end
            end
          end
        end
        ARB_WAIT: begin
          busy      = 1'b1;
          timer_dec = 1'b1;
          if (timer_done) begin
            if (owner_q == OWN_IF) begin
              if_rdata_d = mem_rdata;
            end else begin
              dm_rdata_d = mem_rdata;
            end
            state_d = ARB_RESP;
          end
        end
        ARB_RESP: begin
          busy     = 1'b1;
          if_valid = (owner_q == OWN_IF);
          dm_valid = (owner_q == OWN_DM);
          state_d  = ARB_IDLE;
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWN_IF;
      starve_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: issue-vector table, hand-written corner
// sequences and a randomized run against a transaction-level model.
module tb_mem_port_arbiter;
  import riscv_pkg::*;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int BE_W         = 4;
  localparam int MEM_LAT      = 2;
  localparam int STARVE_LIMIT = 2;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [BE_W-1:0]   dm_be;
  logic              dm_valid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  arb_state_t        dbg_state;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model: 64 words, 2-cycle read latency ----------------
  logic [31:0] ram [0:63];
  logic [31:0] rd_p1, rd_p2;
  logic        init_we;
  logic [5:0]  init_idx;
  logic [31:0] init_data;
  assign mem_rdata = rd_p2;

  always @(posedge clk) begin
    if (mem_en && !mem_we) rd_p1 <= ram[mem_addr[7:2]];
    else                   rd_p1 <= 32'hDEADBEEF;
    rd_p2 <= rd_p1;
    if (init_we) begin
      ram[init_idx] <= init_data;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < BE_W; b++)
        if (mem_be[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ram_load(input int idx, input logic [31:0] data);
    init_idx  = 6'(idx);
    init_data = data;
    init_we   = 1'b1;
    next_cycle();
    init_we   = 1'b0;
  endtask

  task automatic do_reset();
    next_cycle();
    rst    = 1'b1;
    if_req = 1'b0;
    dm_req = 1'b0;
    dm_we  = 1'b0;
    next_cycle();
    rst    = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- issue-vector table ----------------
  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
  } vec_t;

  vec_t vecs [5];

  // ---------------- scoreboard / model state for the random run ----------------
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_q [$];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int own_seen [$];
    int cyc_seen [$];
    int exp_own [6];
    logic [31:0] v;

    vecs[0] = '{1'b0, 32'h60, 1'b0, 1'b1, 32'h64, 32'hFFFF, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
    vecs[1] = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h44, 32'h55, 4'h3, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF};
    vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h48, 32'h1234, 4'h5, 1'b1, 1'b0, 32'h48, 32'h1234, 4'h5};
    vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h4C, 32'hCAFEF00D, 4'hA, 1'b1, 1'b1, 32'h4C, 32'hCAFEF00D, 4'hA};
    vecs[4] = '{1'b1, 32'h50, 1'b1, 1'b1, 32'h54, 32'h77, 4'hC, 1'b1, 1'b1, 32'h54, 32'h77, 4'hC};
    exp_own = '{1, 1, 0, 1, 1, 0};

    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; dm_be = '0; init_we = 1'b0; init_idx = '0; init_data = '0;
    for (int i = 0; i < 64; i++) ram_load(i, 32'h1000_0000 + 32'(i));
    ram_load(4, 32'h00500093);

    // Reset with both requests asserted
    if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_addr = 32'h4;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_dm_valid", dm_valid, 0);
      if (k == 1) begin
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_state", dbg_state, ARB_IDLE);
      end
      next_cycle();
    end
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;

    // Issue-vector table
    for (int i = 0; i < 5; i++) begin
      do_reset();
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we; dm_addr = vecs[i].dm_addr;
      dm_wdata = vecs[i].dm_wdata; dm_be = vecs[i].dm_be;
      @(negedge clk);
      chk("vec_mem_en", mem_en, vecs[i].e_en);
      chk("vec_mem_we", mem_we, vecs[i].e_we);
      chk("vec_mem_addr", mem_addr, vecs[i].e_addr);
      chk("vec_mem_wdata", mem_wdata, vecs[i].e_wdata);
      chk("vec_mem_be", mem_be, vecs[i].e_be);
      next_cycle();
      if_req = 1'b0; dm_req = 1'b0;
      for (int k = 0; k < 4; k++) next_cycle();
    end

    // Fetch with 2-cycle latency
    do_reset();
    next_cycle();
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    chk("fetch_mem_en", mem_en, 1);
    chk("fetch_mem_we", mem_we, 0);
    chk("fetch_mem_addr", mem_addr, 32'h10);
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      @(negedge clk);
      chk("fetch_if_valid", if_valid, (k == 3));
      chk("fetch_busy", busy, 1);
      if (k == 3) chk("fetch_if_rdata", if_rdata, 32'h00500093);
    end
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    chk("fetch_valid_drop", if_valid, 0);
    chk("fetch_rdata_hold", if_rdata, 32'h00500093);
    chk("fetch_busy_idle", busy, 0);

    // Store, partial store, load
    next_cycle();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h4; dm_wdata = 32'hABCD1234; dm_be = 4'hF;
    @(negedge clk);
    chk("st1_mem_en", mem_en, 1);
    chk("st1_mem_we", mem_we, 1);
    chk("st1_mem_wdata", mem_wdata, 32'hABCD1234);
    chk("st1_mem_be", mem_be, 4'hF);
    next_cycle();
    @(negedge clk);
    chk("st1_dm_valid", dm_valid, 1);
    chk("st1_busy", busy, 1);
    next_cycle();
    dm_wdata = 32'h000000FF; dm_be = 4'h1;
    @(negedge clk);
    chk("st2_mem_en", mem_en, 1);
    chk("st2_dm_valid", dm_valid, 0);
    chk("st2_mem_be", mem_be, 4'h1);
    next_cycle();
    @(negedge clk);
    chk("st2_dm_valid", dm_valid, 1);
    next_cycle();
    dm_we = 1'b0;
    @(negedge clk);
    chk("ld_mem_en", mem_en, 1);
    chk("ld_mem_we", mem_we, 0);
    chk("ld_mem_addr", mem_addr, 32'h4);
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      @(negedge clk);
      chk("ld_dm_valid", dm_valid, (k == 3));
      if (k == 3) chk("ld_dm_rdata", dm_rdata, 32'hABCD12FF);
    end
    next_cycle();
    dm_req = 1'b0;
    @(negedge clk);
    chk("ld_valid_drop", dm_valid, 0);

    // Contention: both requesters read continuously
    do_reset();
    if_req = 1'b1; if_addr = 32'h20; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h24;
    for (int k = 0; k < 40 && own_seen.size() < 6; k++) begin
      @(negedge clk);
      if (mem_en) begin
        own_seen.push_back((mem_addr == 32'h24) ? 1 : 0);
        cyc_seen.push_back(k);
      end
      next_cycle();
    end
    if_req = 1'b0; dm_req = 1'b0;
    chk("cont_issue_count", 64'(own_seen.size()), 6);
    for (int i = 0; i < own_seen.size() && i < 6; i++) begin
      chk("cont_owner", 64'(own_seen[i]), 64'(exp_own[i]));
      if (i > 0) chk("cont_spacing", 64'(cyc_seen[i] - cyc_seen[i-1]), 4);
    end
    for (int k = 0; k < 4; k++) next_cycle();

    // Reset in the middle of a fetch
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    chk("rmid_issue", mem_en, 1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("rmid_valid_t1", if_valid, 0);
    next_cycle();
    rst = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("rmid_state_t2", dbg_state, ARB_IDLE);
    chk("rmid_busy_t2", busy, 0);
    chk("rmid_valid_t2", if_valid, 0);
    next_cycle();
    @(negedge clk);
    chk("rmid_valid_t3", if_valid, 0);
    chk("rmid_rdata_t3", if_rdata, 0);
    chk("rmid_state_t3", dbg_state, ARB_IDLE);

    // Back-to-back stores
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF;
        dm_addr = 32'h80 + 32'(4 * (i / 2));
        dm_wdata = 32'h5A5A0000 + 32'(i);
      end
      @(negedge clk);
      chk("b2b_mem_en", mem_en, (i % 2 == 0));
      chk("b2b_busy", busy, (i % 2 == 1));
      chk("b2b_dm_valid", dm_valid, (i % 2 == 1));
      next_cycle();
    end
    dm_req = 1'b0; dm_we = 1'b0;
    next_cycle();
    for (int i = 0; i < 4; i++) chk("b2b_ram", ram[32 + i], 32'h5A5A0000 + 32'(2 * i));

    // Randomized run against a transaction-level model
    do_reset();
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      ram_load(i, v);
      ref_mem[i] = v;
    end
    begin
      int c, free_at, issue_c, if_vc, dm_vc, starve;
      bit if_pend, dm_pend, dm_is_load;
      logic [31:0] if_pdata, dm_pdata, if_rexp, dm_rexp;
      logic e_en, e_we;
      logic [31:0] e_addr, e_wd;
      logic [3:0] e_be;
      c = 0; free_at = 0; issue_c = -1; if_vc = -1; dm_vc = -1; starve = 0;
      if_pend = 0; dm_pend = 0; dm_is_load = 0;
      if_pdata = '0; dm_pdata = '0; if_rexp = '0; dm_rexp = '0;
      for (int n = 0; n < 600; n++) begin
        next_cycle();
        if (!if_pend && $urandom_range(0, 1) == 1) begin
          if_pend = 1'b1;
          if_addr = 32'($urandom_range(0, 63)) << 2;
        end
        if (!dm_pend && $urandom_range(0, 2) != 0) begin
          dm_pend  = 1'b1;
          dm_we    = 1'($urandom_range(0, 1));
          dm_addr  = 32'($urandom_range(0, 63)) << 2;
          dm_wdata = $urandom;
          dm_be    = 4'($urandom_range(0, 15));
        end
        if_req = if_pend;
        dm_req = dm_pend;

        e_en = 0; e_we = 0; e_addr = '0; e_wd = '0; e_be = '0;
        if (c >= free_at && (if_pend || dm_pend)) begin
          e_en = 1'b1;
          issue_c = c;
          if (if_pend && (!dm_pend || starve == STARVE_LIMIT)) begin
            starve   = 0;
            e_addr   = if_addr;
            e_be     = 4'hF;
            if_pdata = ref_mem[if_addr[7:2]];
            if_vc    = c + MEM_LAT + 1;
            free_at  = if_vc + 1;
          end else begin
            if (if_pend && starve < STARVE_LIMIT) starve++;
            e_we = dm_we; e_addr = dm_addr; e_wd = dm_wdata; e_be = dm_be;
            if (dm_we) begin
              for (int b = 0; b < BE_W; b++)
                if (dm_be[b]) ref_mem[dm_addr[7:2]][8*b +: 8] = dm_wdata[8*b +: 8];
              dm_is_load = 1'b0;
              dm_vc = c + 1;
            end else begin
              dm_pdata   = ref_mem[dm_addr[7:2]];
              dm_is_load = 1'b1;
              dm_vc      = c + MEM_LAT + 1;
            end
            free_at = dm_vc + 1;
          end
        end
        if (c == if_vc) if_rexp = if_pdata;
        if (c == dm_vc && dm_is_load) dm_rexp = dm_pdata;
        exp_q.push_back(if_rexp);
        exp_q.push_back(dm_rexp);

        @(negedge clk);
        chk("rnd_mem_en", mem_en, e_en);
        chk("rnd_mem_we", mem_we, e_we);
        chk("rnd_mem_addr", mem_addr, e_addr);
        chk("rnd_mem_wdata", mem_wdata, e_wd);
        chk("rnd_mem_be", mem_be, e_be);
        chk("rnd_if_valid", if_valid, (c == if_vc));
        chk("rnd_dm_valid", dm_valid, (c == dm_vc));
        chk("rnd_if_rdata", if_rdata, exp_q.pop_front());
        chk("rnd_dm_rdata", dm_rdata, exp_q.pop_front());
        chk("rnd_busy", busy, (c > issue_c) && (c < free_at));
        if (c == if_vc) if_pend = 1'b0;
        if (c == dm_vc) dm_pend = 1'b0;
        c++;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
